arm_control_unit: RTL and testbench
===================================

Name: arm_control_unit

Overview:
- Sequencing controller for the ARM single-cycle `datapath`.
- Decodes `instr` and drives every datapath control input.
- Owns the registered NZCV flags used for conditional execution.
- Stalls the PC through a request/ready handshake with data memory, with an optional timeout and a sticky error flag.

Parameters:
- MEM_TIMEOUT, 15, number of `MEM_WAIT` cycles before a memory access is aborted; 0 disables the timeout.
- TO_W, 4, width of the wait counter; must satisfy MEM_TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  current instruction; held stable by upstream while pcEn=0.
- ALUFlags  in  4  {N,Z,C,V} from the datapath ALU, current cycle.
- memReady  in  1  data memory completes the access this cycle.
- regSrc  out  2  [0]=R15 as Rn (branch); [1]=Rd as second read address (STR).
- regWrite  out  1  register file write enable.
- immSrc  out  2  00=imm8 rot, 01=imm12, 10=imm24 branch.
- ALUSrc  out  1  1 = extended immediate as ALU operand B.
- ALUControl  out  4  ALU operation (package encoding).
- memToReg  out  1  result mux selects readData.
- PCSrc  out  1  PC loads ALUResult/readData.
- memWrite  out  1  store strobe, valid with memReq.
- memReq  out  1  data memory access request.
- pcEn  out  1  PC register update enable.
- memErr  out  1  sticky: a memory access timed out.

Behaviour:
- Reset (clk edge with reset=1):
  - state=EXEC, flags=0000, wait counter=0, memErr=0.
  - While reset is high: regWrite, memWrite, memReq, pcEn and PCSrc are forced to 0.
- Decode fields: cond=instr[31:28], op=instr[27:26], I=instr[25], cmd=instr[24:21], S=instr[20], U=instr[23], L=instr[20], Rd=instr[15:12].
- condEx is computed from the registered flags, not ALUFlags:
  - Full ARM table EQ..LE, AL=1110 always true.
  - 1111 is never true.
- Data processing (op=00):
  - immSrc=00, ALUSrc=I.
  - cmd mapping: ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001, MOV 1101, CMP 1010. CMP forces S and never writes a register.
  - Other cmd values: NOP.
  - regWrite=condEx & !CMP.
  - PCSrc=regWrite & Rd==15.
  - Completes in one cycle: pcEn=1.
- Flag update, at the EXEC edge, when data-proc & condEx & S:
  - N and Z always load from ALUFlags.
  - C and V load only for ADD/SUB/CMP; otherwise they are held.
- Branch (op=10):
  - immSrc=10, ALUSrc=1, regSrc[0]=1, ALUControl=ADD.
  - PCSrc=condEx, regWrite=0, pcEn=1.
- Memory (op=01):
  - immSrc=01, ALUSrc=1, ALUControl=ADD if U else SUB.
  - regSrc[1]=!L, memWrite=!L.
  - If !condEx: behaves as NOP with pcEn=1.
- Undefined op=11: NOP, pcEn=1, no writes.
- FSM states: EXEC, MEM_WAIT.
- EXEC with a condEx memory instruction:
  - memReq=1.
  - If memReady=1 in the same cycle: complete now. For LDR, regWrite=1 and memToReg=1, with PCSrc=1 if Rd==15. Then pcEn=1 and stay in EXEC.
  - Otherwise: pcEn=0, regWrite=0, go to MEM_WAIT, counter=0.
- MEM_WAIT:
  - memReq and memWrite held, all other decode outputs held from instr; pcEn=0.
  - When memReady=1: complete exactly as above and return to EXEC.
  - Otherwise the counter increments.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with memReady=0: abort. Set memErr=1, pcEn=1, no register write, return to EXEC.
  - memReady and timeout in the same cycle: memReady wins, no error.
- memReady sampled outside a memory access is ignored.
- Reset during MEM_WAIT:
  - Returns to EXEC with no write and memReq=0 from that edge on.
  - memErr is cleared.
- Total latency: 1 cycle for every non-memory instruction; 1+k cycles for a memory access where memReady arrives k cycles after the request.

Decomposition:
- Package `arm_ctrl_pkg`:
  - ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_ORR=4'h3, ALU_EOR=4'h4, ALU_MOV=4'h5.
  - op, cmd and cond constants.
  - immSrc encodings.
  - FSM state typedef.
- One sub-module `arm_cond_check`: holds the flag register and computes condEx. Inputs: cond, ALUFlags, flagW[1:0], clk, reset.

Test Plan:
- Reset held 2 cycles with instr=E0921003 (ADDS R1,R2,R3) → regWrite=0, pcEn=0, memReq=0; after release the same instr gives regWrite=1, ALUControl=0, ALUSrc=0, pcEn=1.
- Flags and condition, driven on consecutive cycles:
  - ADDS with ALUFlags=0100 (Z set) → flags=0100.
  - Next instr 0A000002 (BEQ) → PCSrc=1, immSrc=10, regSrc[0]=1.
  - With flags=0000, the same BEQ → PCSrc=0, pcEn=1.
- Conditional skip: instr 10921003 (ADDSNE) with flags Z=1 → regWrite=0; flags unchanged when ALUFlags=1001.
- LDR E5901004, memReady low 3 cycles then high:
  - memReq=1 for 4 cycles, pcEn=0 for 3 cycles.
  - On the 4th cycle regWrite=1, memToReg=1, pcEn=1.
- STR E5801004 with memReady=1 in the same cycle → memWrite=1, memReq=1, regSrc[1]=1, pcEn=1, single cycle.
- Timeout: MEM_TIMEOUT=15, LDR with memReady never asserted:
  - Abort on the 16th wait cycle: memErr=1, pcEn=1, regWrite=0.
  - memErr stays 1 until reset.

Source files
------------

// File: rtl/arm_control_unit_pkg.sv
// Shared encodings for the ARM single-cycle control unit.
// ALU opcodes, instruction fields, immediate selects and FSM states.
package arm_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_ORR = 4'h3;
  localparam logic [3:0] ALU_EOR = 4'h4;
  localparam logic [3:0] ALU_MOV = 4'h5;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  typedef enum logic {
    S_EXEC,
    S_MEM_WAIT
  } state_e;

endpackage

// File: rtl/arm_control_unit_if.sv
// Data-memory request/ready handshake between controller and memory.
// The controller is master; memory answers with memReady.
interface arm_control_unit_if;
  logic memReq;
  logic memWrite;
  logic memReady;

  modport master (
    output memReq,
    output memWrite,
    input  memReady
  );

  modport slave (
    input  memReq,
    input  memWrite,
    output memReady
  );
endinterface

// File: rtl/arm_control_unit_cond_check.sv
// NZCV flag register and condition evaluation against registered flags.
// flagW[1] loads N,Z; flagW[0] loads C,V.
module arm_cond_check (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] flagW,
  output logic       condEx
);
  import arm_ctrl_pkg::*;

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (flagW[1]) flags_d[3:2] = ALUFlags[3:2];
    if (flagW[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  always_comb begin
    condEx = 1'b0;
    unique case (cond)
      COND_EQ: condEx = z;
      COND_NE: condEx = !z;
      COND_CS: condEx = c;
      COND_CC: condEx = !c;
      COND_MI: condEx = n;
      COND_PL: condEx = !n;
      COND_VS: condEx = v;
      COND_VC: condEx = !v;
      COND_HI: condEx = c && !z;
      COND_LS: condEx = !(c && !z);
      COND_GE: condEx = (n == v);
      COND_LT: condEx = (n != v);
      COND_GT: condEx = !z && (n == v);
      COND_LE: condEx = !(!z && (n == v));
      COND_AL: condEx = 1'b1;
      COND_NV: condEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_control_unit.sv
// Decoder and sequencer for the ARM single-cycle datapath.
// Memory accesses stall the PC until memReady or timeout.
module arm_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic [3:0]          ALUFlags,
  arm_control_unit_if.master  mem,
  output logic [1:0]          regSrc,
  output logic                regWrite,
  output logic [1:0]          immSrc,
  output logic                ALUSrc,
  output logic [3:0]          ALUControl,
  output logic                memToReg,
  output logic                PCSrc,
  output logic                pcEn,
  output logic                memErr
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit, u_bit, l_bit;
  logic       unused_instr;

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign i_bit = instr[25];
  assign cmd   = instr[24:21];
  assign s_bit = instr[20];
  assign u_bit = instr[23];
  assign l_bit = instr[20];
  assign rd    = instr[15:12];
  assign unused_instr = ^{instr[19:16], instr[11:0]};

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [1:0]      flagW;
  logic            condEx;
  logic            mem_req, mem_wr;

  logic [3:0] dp_alu;
  logic       dp_ok, dp_arith, dp_cmp;
  logic       to_hit;

  arm_cond_check u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .ALUFlags (ALUFlags),
    .flagW    (flagW),
    .condEx   (condEx)
  );

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_ok    = 1'b1;
    dp_arith = 1'b0;
    dp_cmp   = 1'b0;
    case (cmd)
      CMD_ADD: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
      CMD_SUB: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
      CMD_AND: dp_alu = ALU_AND;
      CMD_ORR: dp_alu = ALU_ORR;
      CMD_EOR: dp_alu = ALU_EOR;
      CMD_MOV: dp_alu = ALU_MOV;
      CMD_CMP: begin
        dp_alu   = ALU_SUB;
        dp_arith = 1'b1;
        dp_cmp   = 1'b1;
      end
      default: dp_ok = 1'b0;
    endcase
  end

  assign to_hit = (MEM_TIMEOUT != 0) && (cnt_q == TO_LIM);

  always_comb begin
    regSrc     = 2'b00;
    regWrite   = 1'b0;
    immSrc     = IMM_DP;
    ALUSrc     = 1'b0;
    ALUControl = ALU_ADD;
    memToReg   = 1'b0;
    PCSrc      = 1'b0;
    mem_wr     = 1'b0;
    mem_req    = 1'b0;
    pcEn       = 1'b1;
    flagW      = 2'b00;
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    unique case (op)
      OP_DP: begin
        ALUSrc     = i_bit;
        ALUControl = dp_alu;
        if (dp_ok) begin
          regWrite = condEx && !dp_cmp;
          PCSrc    = regWrite && (rd == 4'hF);
          if (condEx && (s_bit || dp_cmp))
            flagW = {1'b1, dp_arith};
        end
      end
      OP_BR: begin
        immSrc     = IMM_BR;
        ALUSrc     = 1'b1;
        regSrc[0]  = 1'b1;
        PCSrc      = condEx;
      end
      OP_MEM: begin
        immSrc     = IMM_MEM;
        ALUSrc     = 1'b1;
        ALUControl = u_bit ? ALU_ADD : ALU_SUB;
        regSrc[1]  = !l_bit;
        memToReg   = l_bit;
        // Once waiting, the access is committed regardless of condEx
        if (condEx || state_q == S_MEM_WAIT) begin
          mem_req = 1'b1;
          mem_wr  = !l_bit;
          if (mem.memReady) begin
            regWrite = l_bit;
            PCSrc    = l_bit && (rd == 4'hF);
            state_d  = S_EXEC;
            cnt_d    = '0;
          end else if (state_q == S_EXEC) begin
            pcEn    = 1'b0;
            state_d = S_MEM_WAIT;
            cnt_d   = '0;
          end else if (to_hit) begin
            err_d   = 1'b1;
            state_d = S_EXEC;
            cnt_d   = '0;
          end else begin
            pcEn  = 1'b0;
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end
      OP_UND: begin
        pcEn = 1'b1;
      end
    endcase

    if (reset) begin
      regWrite = 1'b0;
      PCSrc    = 1'b0;
      mem_wr   = 1'b0;
      mem_req  = 1'b0;
      pcEn     = 1'b0;
      flagW    = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EXEC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem.memReq   = mem_req;
  assign mem.memWrite = mem_wr;
  assign memErr       = err_q;

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed scoreboard bench for arm_control_unit.
// Expected output vectors are queued at drive time and popped at sample time.
module tb_arm_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  regSrc, immSrc;
  logic        regWrite, ALUSrc, memToReg, PCSrc, pcEn, memErr;
  logic [3:0]  ALUControl;

  arm_control_unit_if mif ();

  arm_control_unit #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .ALUFlags   (ALUFlags),
    .mem        (mif),
    .regSrc     (regSrc),
    .regWrite   (regWrite),
    .immSrc     (immSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .memToReg   (memToReg),
    .PCSrc      (PCSrc),
    .pcEn       (pcEn),
    .memErr     (memErr)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDS   = 32'hE0921003;
  localparam logic [31:0] ADDSNE = 32'h10921003;
  localparam logic [31:0] ANDS   = 32'hE0121003;
  localparam logic [31:0] CMP    = 32'hE1520003;
  localparam logic [31:0] BEQ    = 32'h0A000002;
  localparam logic [31:0] BMI    = 32'h4A000002;
  localparam logic [31:0] BCS    = 32'h2A000002;
  localparam logic [31:0] BVS    = 32'h6A000002;
  localparam logic [31:0] LDR    = 32'hE5901004;
  localparam logic [31:0] LDRNE  = 32'h15901004;
  localparam logic [31:0] LDRPC  = 32'hE590F004;
  localparam logic [31:0] LDRSUB = 32'hE5101004;
  localparam logic [31:0] STR    = 32'hE5801004;
  localparam logic [31:0] UND    = 32'hEC000000;

  localparam logic [15:0] M_ALL  = 16'hFFFF;
  localparam logic [15:0] M_NMTR = 16'hFFDF;
  localparam logic [15:0] M_RST  = 16'h201E;
  localparam logic [15:0] M_RSTE = 16'h201F;

  typedef struct {
    string       tag;
    logic [15:0] e;
    logic [15:0] m;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  logic [15:0] obs;
  assign obs = {regSrc, regWrite, immSrc, ALUSrc, ALUControl, memToReg,
                PCSrc, mif.memWrite, mif.memReq, pcEn, memErr};

  function automatic logic [15:0] ev(
    logic [1:0] rs, logic rw, logic [1:0] is, logic as, logic [3:0] alu,
    logic m2r, logic pcs, logic mw, logic mr, logic pe, logic er);
    return {rs, rw, is, as, alu, m2r, pcs, mw, mr, pe, er};
  endfunction

  function automatic logic [15:0] e_adds(logic er);
    return ev(2'b00, 1, 2'b00, 0, 4'h0, 0, 0, 0, 0, 1, er);
  endfunction

  function automatic logic [15:0] e_br(logic taken);
    return ev(2'b01, 0, 2'b10, 1, 4'h0, 0, taken, 0, 0, 1, 0);
  endfunction

  function automatic logic [15:0] e_ldw(logic pe, logic er);
    return ev(2'b00, 0, 2'b01, 1, 4'h0, 0, 0, 0, 1, pe, er);
  endfunction

  task automatic step(string tag, logic rst, logic [31:0] in,
                      logic [3:0] fl, logic rdy,
                      logic [15:0] e, logic [15:0] m);
    sb_t x;
    reset        = rst;
    instr        = in;
    ALUFlags     = fl;
    mif.memReady = rdy;
    sb.push_back('{tag, e, m});
    @(negedge clk);
    x = sb.pop_front();
    n_chk++;
    assert ((obs & x.m) === (x.e & x.m)) n_pass++;
    else $error("FAIL %s: observed %h expected %h (mask %h)",
                x.tag, obs & x.m, x.e & x.m, x.m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    instr        = ADDS;
    ALUFlags     = 4'b0000;
    mif.memReady = 1'b0;
    @(posedge clk);
    #1;

    step("rst0", 1, ADDS, 4'b0100, 0, 16'h0000, M_RSTE);
    step("rst1", 1, ADDS, 4'b0100, 0, 16'h0000, M_RSTE);
    step("adds", 0, ADDS, 4'b0100, 0, e_adds(0), M_ALL);
    step("beq_t", 0, BEQ, 4'b0000, 0, e_br(1), M_ALL);
    step("adds_z0", 0, ADDS, 4'b0000, 0, e_adds(0), M_ALL);
    step("beq_f", 0, BEQ, 4'b0000, 0, e_br(0), M_ALL);
    step("adds_z1", 0, ADDS, 4'b0100, 0, e_adds(0), M_ALL);
    step("addsne", 0, ADDSNE, 4'b1001, 0,
         ev(2'b00, 0, 2'b00, 0, 4'h0, 0, 0, 0, 0, 1, 0), M_ALL);
    step("beq_hold", 0, BEQ, 4'b0000, 0, e_br(1), M_ALL);
    step("bmi_hold", 0, BMI, 4'b0000, 0, e_br(0), M_ALL);

    step("adds_cv", 0, ADDS, 4'b0011, 0, e_adds(0), M_ALL);
    step("ands", 0, ANDS, 4'b1000, 0,
         ev(2'b00, 1, 2'b00, 0, 4'h2, 0, 0, 0, 0, 1, 0), M_ALL);
    step("bvs_held", 0, BVS, 4'b0000, 0, e_br(1), M_ALL);
    step("bcs_held", 0, BCS, 4'b0000, 0, e_br(1), M_ALL);
    step("bmi_new", 0, BMI, 4'b0000, 0, e_br(1), M_ALL);
    step("beq_nz", 0, BEQ, 4'b0000, 0, e_br(0), M_ALL);
    step("cmp", 0, CMP, 4'b0110, 0,
         ev(2'b00, 0, 2'b00, 0, 4'h1, 0, 0, 0, 0, 1, 0), M_ALL);
    step("beq_cmp", 0, BEQ, 4'b0000, 0, e_br(1), M_ALL);
    step("ldrne_skip", 0, LDRNE, 4'b0000, 1,
         ev(2'b00, 0, 2'b01, 1, 4'h0, 0, 0, 0, 0, 1, 0), M_NMTR);

    step("ldr_w0", 0, LDR, 4'b0000, 0, e_ldw(0, 0), M_NMTR);
    step("ldr_w1", 0, LDR, 4'b0000, 0, e_ldw(0, 0), M_NMTR);
    step("ldr_w2", 0, LDR, 4'b0000, 0, e_ldw(0, 0), M_NMTR);
    step("ldr_done", 0, LDR, 4'b0000, 1,
         ev(2'b00, 1, 2'b01, 1, 4'h0, 1, 0, 0, 1, 1, 0), M_ALL);
    step("adds_rdy", 0, ADDS, 4'b0000, 1, e_adds(0), M_ALL);
    step("undef", 0, UND, 4'b0000, 1,
         ev(2'b00, 0, 2'b00, 0, 4'h0, 0, 0, 0, 0, 1, 0), M_ALL);
    step("str", 0, STR, 4'b0000, 1,
         ev(2'b10, 0, 2'b01, 1, 4'h0, 0, 0, 1, 1, 1, 0), M_ALL);
    step("ldr_pc", 0, LDRPC, 4'b0000, 1,
         ev(2'b00, 1, 2'b01, 1, 4'h0, 1, 1, 0, 1, 1, 0), M_ALL);
    step("ldr_sub", 0, LDRSUB, 4'b0000, 1,
         ev(2'b00, 1, 2'b01, 1, 4'h1, 1, 0, 0, 1, 1, 0), M_ALL);

    step("to_exec", 0, LDR, 4'b0000, 0, e_ldw(0, 0), M_NMTR);
    for (int i = 0; i < 15; i++)
      step($sformatf("to_wait%0d", i), 0, LDR, 4'b0000, 0,
           e_ldw(0, 0), M_NMTR);
    step("to_abort", 0, LDR, 4'b0000, 0, e_ldw(1, 0), M_NMTR);
    step("err_set", 0, ADDS, 4'b0000, 0, e_adds(1), M_ALL);
    step("err_hold", 0, ADDS, 4'b0000, 0, e_adds(1), M_ALL);

    step("rw_exec", 0, LDR, 4'b0000, 0, e_ldw(0, 1), M_NMTR);
    step("rw_wait", 0, LDR, 4'b0000, 0, e_ldw(0, 1), M_NMTR);
    step("rw_rst", 1, LDR, 4'b0000, 0, 16'h0000, M_RST);
    step("rw_rst2", 1, ADDS, 4'b0000, 0, 16'h0000, M_RSTE);
    step("rw_rel", 0, ADDS, 4'b0000, 0, e_adds(0), M_ALL);
    step("rw_ldr", 0, LDR, 4'b0000, 1,
         ev(2'b00, 1, 2'b01, 1, 4'h0, 1, 0, 0, 1, 1, 0), M_ALL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
